// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronises a raw button level, then accepts a new
// level only after it has been stable for STABLE_SAMPLES sample_tick pulses.
// Emits a registered clean level plus single-cycle rise/fall pulses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE_LOW  | accepted level is 0, synchronised input agrees
// WAIT_HIGH | input went high, counting stable ticks before accepting 1
// HIGH      | accepted level is 1, synchronised input agrees
// WAIT_LOW  | input went low, counting stable ticks before accepting 0
module btn_debounce #(
  parameter int STABLE_SAMPLES = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_tick,
  input  logic btn_in,
  output logic db_level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam int CW = $clog2(STABLE_SAMPLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_SAMPLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;

  state_t        state_q, state_d;
  logic [CW-1:0] scnt_q, scnt_d;
  logic          db_d, rise_d, fall_d, busy_d;

  // Synchroniser runs on every clk; the sample tick only gates counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

  // State, stability counter and all outputs are registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE_LOW;
      scnt_q     <= '0;
      db_level   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      db_level   <= db_d;
      rise_pulse <= rise_d;
      fall_pulse <= fall_d;
      busy       <= busy_d;
    end
  end

  // Next-state logic; an input reversal during a wait aborts before any tick is counted.
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    db_d    = db_level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    case (state_q)
      IDLE_LOW: begin
        if (btn_s) begin
          state_d = WAIT_HIGH;
          scnt_d  = '0;
        end
      end

      WAIT_HIGH: begin
        if (!btn_s) begin
          state_d = IDLE_LOW;
          scnt_d  = '0;
        end else if (sample_tick) begin
          if (scnt_q == LAST) begin
            state_d = HIGH;
            scnt_d  = '0;
            db_d    = 1'b1;
            rise_d  = 1'b1;
          end else begin
            scnt_d = scnt_q + CW'(1);
          end
        end
      end

      HIGH: begin
        if (!btn_s) begin
          state_d = WAIT_LOW;
          scnt_d  = '0;
        end
      end

      WAIT_LOW: begin
        if (btn_s) begin
          state_d = HIGH;
          scnt_d  = '0;
        end else if (sample_tick) begin
          if (scnt_q == LAST) begin
            state_d = IDLE_LOW;
            scnt_d  = '0;
            db_d    = 1'b0;
            fall_d  = 1'b1;
          end else begin
            scnt_d = scnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE_LOW;
        scnt_d  = '0;
      end
    endcase

    // busy is registered from the next state so it tracks the state register exactly.
    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

endmodule
